// File: rtl/systolic_sequencer_if.sv
// Job/control bundle between the host register file and systolic_sequencer.
// The master side issues jobs; the slave side (the sequencer) drives status, latched config and strobes.
interface systolic_sequencer_if #(
    parameter int ARRAY_N    = 8,
    parameter int ARRAY_M    = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int K_WIDTH    = 8
);
    localparam int RW = $clog2(ARRAY_N) + 1;
    localparam int CW = $clog2(ARRAY_M) + 1;

    logic                  start;
    logic                  cfg_mode;
    logic [RW-1:0]         cfg_rows;
    logic [CW-1:0]         cfg_cols;
    logic [K_WIDTH-1:0]    cfg_k_len;
    logic [ADDR_WIDTH-1:0] cfg_a_base;
    logic [ADDR_WIDTH-1:0] cfg_w_base;
    logic [ADDR_WIDTH-1:0] cfg_o_base;

    logic                  busy;
    logic                  done;
    logic                  err;
    logic                  mode;
    logic [RW-1:0]         a_num_rows;
    logic [CW-1:0]         w_num_cols;
    logic [ADDR_WIDTH-1:0] a_base_addr;
    logic [ADDR_WIDTH-1:0] w_base_addr;
    logic [ADDR_WIDTH-1:0] o_base_addr;
    logic                  a_buf_on;
    logic                  w_buf_on;
    logic [2:0]            operation_signal_in;
    logic                  o_idx_gen_on;
    logic                  o_ag_o_on;
    logic                  o_drain;

    modport master (
        output start, cfg_mode, cfg_rows, cfg_cols, cfg_k_len,
               cfg_a_base, cfg_w_base, cfg_o_base,
        input  busy, done, err, mode, a_num_rows, w_num_cols,
               a_base_addr, w_base_addr, o_base_addr,
               a_buf_on, w_buf_on, operation_signal_in,
               o_idx_gen_on, o_ag_o_on, o_drain
    );

    modport slave (
        input  start, cfg_mode, cfg_rows, cfg_cols, cfg_k_len,
               cfg_a_base, cfg_w_base, cfg_o_base,
        output busy, done, err, mode, a_num_rows, w_num_cols,
               a_base_addr, w_base_addr, o_base_addr,
               a_buf_on, w_buf_on, operation_signal_in,
               o_idx_gen_on, o_ag_o_on, o_drain
    );
endinterface

// File: rtl/systolic_sequencer.sv
// Job sequencer for systolic_system: validates and latches one descriptor, then
// walks the OS or WS phase list with a down-counter, driving registered strobes.
module systolic_sequencer #(
    parameter int ARRAY_N    = 8,
    parameter int ARRAY_M    = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int K_WIDTH    = 8
) (
    input  logic                clk,
    input  logic                reset,
    systolic_sequencer_if.slave bus
);
    localparam int RW = $clog2(ARRAY_N) + 1;
    localparam int CW = $clog2(ARRAY_M) + 1;
    localparam int PW = K_WIDTH + 1;

    typedef logic [PW-1:0] len_t;
    localparam len_t ONE   = len_t'(1);
    localparam len_t N_LEN = len_t'(ARRAY_N);
    localparam logic [RW-1:0] MAX_ROWS = RW'(ARRAY_N);
    localparam logic [CW-1:0] MAX_COLS = CW'(ARRAY_M);

    typedef enum logic [3:0] {
        S_IDLE, S_OS_FEED, S_OS_FLUSH, S_OS_WAIT, S_OS_STORE,
        S_WS_LOAD, S_WS_FLOW, S_WS_OUT, S_WS_DRAIN, S_DONE
    } state_t;

    state_t                state, state_n;
    len_t                  cnt, cnt_n;
    logic                  accept, reject, cfg_valid, last;

    logic                  mode_q;
    logic [RW-1:0]         rows_q;
    logic [CW-1:0]         cols_q;
    logic [K_WIDTH-1:0]    k_q;
    logic [ADDR_WIDTH-1:0] a_base_q, w_base_q, o_base_q;

    logic       busy_q, done_q, err_q, a_on_q, w_on_q, idx_q, ag_q, drain_q;
    logic [2:0] op_q;
    logic       busy_n, done_n, a_on_n, w_on_n, idx_n, ag_n, drain_n;
    logic [2:0] op_n;

    len_t rows_l, cols_l, k_l, flush_len, wait_len, store_len, out_len, drain_len;

    assign rows_l    = len_t'(rows_q);
    assign cols_l    = len_t'(cols_q);
    assign k_l       = len_t'(k_q);
    assign flush_len = rows_l + cols_l - ONE;
    assign wait_len  = (N_LEN > rows_l + ONE) ? (N_LEN - rows_l - ONE) : '0;
    assign store_len = rows_l + ONE;
    assign out_len   = k_l + cols_l - ONE;
    assign drain_len = k_l + ONE;

    assign cfg_valid = (bus.cfg_rows != '0) && (bus.cfg_rows <= MAX_ROWS) &&
                       (bus.cfg_cols != '0) && (bus.cfg_cols <= MAX_COLS) &&
                       (bus.cfg_k_len != '0);
    assign last = (cnt == ONE);

    // Only OS_WAIT can have zero length, so it is the only phase that gets bypassed.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        accept  = 1'b0;
        reject  = 1'b0;
        if (state != S_IDLE && state != S_DONE)
            cnt_n = cnt - ONE;
        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    if (cfg_valid) begin
                        accept = 1'b1;
                        if (bus.cfg_mode) begin
                            state_n = S_OS_FEED;
                            cnt_n   = len_t'(bus.cfg_k_len);
                        end else begin
                            state_n = S_WS_LOAD;
                            cnt_n   = len_t'(bus.cfg_cols) + ONE;
                        end
                    end else begin
                        reject = 1'b1;
                    end
                end
            end
            S_OS_FEED:  if (last) begin state_n = S_OS_FLUSH; cnt_n = flush_len; end
            S_OS_FLUSH: if (last) begin
                if (wait_len != '0) begin state_n = S_OS_WAIT;  cnt_n = wait_len;  end
                else                begin state_n = S_OS_STORE; cnt_n = store_len; end
            end
            S_OS_WAIT:  if (last) begin state_n = S_OS_STORE; cnt_n = store_len; end
            S_OS_STORE: if (last) begin state_n = S_DONE;     cnt_n = '0;        end
            S_WS_LOAD:  if (last) begin state_n = S_WS_FLOW;  cnt_n = k_l;       end
            S_WS_FLOW:  if (last) begin state_n = S_WS_OUT;   cnt_n = out_len;   end
            S_WS_OUT:   if (last) begin state_n = S_WS_DRAIN; cnt_n = drain_len; end
            S_WS_DRAIN: if (last) begin state_n = S_DONE;     cnt_n = '0;        end
            S_DONE:     begin state_n = S_IDLE; cnt_n = '0; end
            default:    begin state_n = S_IDLE; cnt_n = '0; end
        endcase
    end

    // Strobes are decoded from the next state so they register alongside it.
    always_comb begin
        busy_n  = (state_n != S_IDLE);
        done_n  = (state_n == S_DONE);
        a_on_n  = 1'b0;
        w_on_n  = 1'b0;
        idx_n   = 1'b0;
        ag_n    = 1'b0;
        drain_n = 1'b0;
        op_n    = 3'b000;
        case (state_n)
            S_OS_FEED:  begin a_on_n = 1'b1; w_on_n = 1'b1; op_n = 3'b100; end
            S_OS_FLUSH: op_n = 3'b100;
            S_OS_WAIT:  op_n = 3'b110;
            S_OS_STORE: begin op_n = 3'b110; ag_n = 1'b1; end
            S_WS_LOAD:  begin w_on_n = 1'b1; op_n = 3'b001; end
            S_WS_FLOW:  a_on_n = 1'b1;
            S_WS_OUT:   idx_n = 1'b1;
            S_WS_DRAIN: begin drain_n = 1'b1; ag_n = 1'b1; end
            default:    ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            a_on_q   <= 1'b0;
            w_on_q   <= 1'b0;
            idx_q    <= 1'b0;
            ag_q     <= 1'b0;
            drain_q  <= 1'b0;
            op_q     <= 3'b000;
            mode_q   <= 1'b0;
            rows_q   <= '0;
            cols_q   <= '0;
            k_q      <= '0;
            a_base_q <= '0;
            w_base_q <= '0;
            o_base_q <= '0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            busy_q  <= busy_n;
            done_q  <= done_n;
            err_q   <= reject;
            a_on_q  <= a_on_n;
            w_on_q  <= w_on_n;
            idx_q   <= idx_n;
            ag_q    <= ag_n;
            drain_q <= drain_n;
            op_q    <= op_n;
            if (accept) begin
                mode_q   <= bus.cfg_mode;
                rows_q   <= bus.cfg_rows;
                cols_q   <= bus.cfg_cols;
                k_q      <= bus.cfg_k_len;
                a_base_q <= bus.cfg_a_base;
                w_base_q <= bus.cfg_w_base;
                o_base_q <= bus.cfg_o_base;
            end
        end
    end

    assign bus.busy                = busy_q;
    assign bus.done                = done_q;
    assign bus.err                 = err_q;
    assign bus.mode                = mode_q;
    assign bus.a_num_rows          = rows_q;
    assign bus.w_num_cols          = cols_q;
    assign bus.a_base_addr         = a_base_q;
    assign bus.w_base_addr         = w_base_q;
    assign bus.o_base_addr         = o_base_q;
    assign bus.a_buf_on            = a_on_q;
    assign bus.w_buf_on            = w_on_q;
    assign bus.operation_signal_in = op_q;
    assign bus.o_idx_gen_on        = idx_q;
    assign bus.o_ag_o_on           = ag_q;
    assign bus.o_drain             = drain_q;
endmodule

// File: doc/systolic_sequencer.md
# systolic_sequencer

Control sequencer that drives the `systolic_system` datapath. It accepts one job descriptor: mode, tile shape and base addresses. It then issues the cycle-accurate sequence of buffer-enable, operation and output-buffer strobes for an output-stationary (OS) or weight-stationary (WS) pass. It sits between the host/AXI register file and `systolic_system`, and replaces hand-timed stimulus with a single `start`/`done` handshake.

## Interface
- `ARRAY_N`, 8: array rows; rows accepted in 1..ARRAY_N.
- `ARRAY_M`, 8: array columns; cols accepted in 1..ARRAY_M.
- `ADDR_WIDTH`, 8: buffer address width.
- `K_WIDTH`, 8: width of `k_len` (reduction length M in OS, depth D in WS).

- `clk` input 1: single clock; all logic on rising edge.
- `reset` input 1: synchronous, active-high.
- `start` input 1: job request; sampled only in IDLE.
- `cfg_mode` input 1: 1 = OS, 0 = WS.
- `cfg_rows` input $clog2(ARRAY_N)+1: active rows.
- `cfg_cols` input $clog2(ARRAY_M)+1: active columns.
- `cfg_k_len` input K_WIDTH: OS reduction length / WS depth.
- `cfg_a_base`, `cfg_w_base`, `cfg_o_base` input ADDR_WIDTH each: base addresses.
- `busy` output 1: job in progress, including the DONE cycle.
- `done` output 1: one-cycle completion pulse.
- `err` output 1: one-cycle pulse when a start is rejected.
- `mode`, `a_num_rows`, `w_num_cols`, `a_base_addr`, `w_base_addr`, `o_base_addr` output: latched job config, held stable while busy.
- `a_buf_on`, `w_buf_on` output 1 each: buffer streaming enables.
- `operation_signal_in` output 3: 000 = WS flow, 001 = W load, 100 = OS flow, 110 = OS drain.
- `o_idx_gen_on`, `o_ag_o_on`, `o_drain` output 1 each: output-buffer controls.

## Operation
- All outputs are registered. Reset value of every output is 0.
- Accept rule: in IDLE with `start`=1, the config is validated.
  - Invalid config: rows==0, rows>ARRAY_N, cols==0, cols>ARRAY_M, or k_len==0. Then `err`=1 for one cycle and the block stays IDLE.
  - Valid config: it is latched and the first phase begins.
- `start` outside IDLE is ignored; no err, no effect.
- Each phase loads a down-counter of width K_WIDTH+1. The phase ends when the counter expires.
- A phase of length 0 is skipped entirely (zero cycles, no strobe).
- OS phases, in order:
  - OS_FEED: k_len cycles; a_buf_on=1, w_buf_on=1, op=100.
  - OS_FLUSH: rows+cols-1 cycles; op=100, buffers off.
  - OS_WAIT: max(ARRAY_N-rows-1, 0) cycles; op=110.
  - OS_STORE: rows+1 cycles; op=110, o_ag_o_on=1.
- WS phases, in order:
  - WS_LOAD: cols+1 cycles; w_buf_on=1, op=001.
  - WS_FLOW: k_len cycles; a_buf_on=1, op=000.
  - WS_OUT: k_len+cols-1 cycles; o_idx_gen_on=1, op=000.
  - WS_DRAIN: k_len+1 cycles; o_drain=1, o_ag_o_on=1, op=000.
- DONE: one cycle. done=1, busy=1, all strobes 0, op=000. Then the block returns to IDLE.
- In IDLE all strobes are 0 and op=000. Latched config holds its last value.
- Arithmetic is done at width K_WIDTH+1. The k_len+cols-1 maximum (2^K_WIDTH-1+ARRAY_M-1) must not overflow.

## Timing
- `start` sampled at edge 0. `busy` and the first phase strobes are visible from cycle 1.
- Phase boundaries are back-to-back with no idle cycles between phases.
- `done` cycle = 1 + sum of phase lengths. Next start is accepted at the edge after the DONE cycle.
- `err` is visible in cycle 1 after the rejected start edge. A new start is accepted in that same cycle.
- Reset asserted mid-job: at the next edge the block returns to IDLE with all outputs 0. No done pulse is issued.
- Config inputs changing while busy have no effect.

## Test plan
- OS, rows=6, cols=6, k=15:
  - Cycles 1–15: feed.
  - Cycles 16–26: op=100 with buffers off.
  - Cycle 27: op=110.
  - Cycles 28–34: o_ag_o_on=1.
  - done at cycle 35.
- WS, rows=5, cols=5, k=8:
  - Cycles 1–6: w_buf_on, op=001.
  - Cycles 7–14: a_buf_on.
  - Cycles 15–26: o_idx_gen_on.
  - Cycles 27–35: o_drain and o_ag_o_on.
  - done at cycle 36.
- OS, rows=8, cols=8, k=4:
  - OS_WAIT is skipped.
  - Cycles 1–4: feed. Cycles 5–19: flush. Cycles 20–28: store.
  - done at cycle 29.
- start with cols=9, then with k_len=0: each gives an err pulse; busy stays 0 and all strobes stay 0.
- start pulses at cycles 5 and 10 during an OS job are ignored. Exactly one done pulse is issued, and latched config is unchanged after cfg inputs are altered.
- reset at cycle 10 of the WS job: all outputs are 0 the next cycle with no done pulse. A fresh start then completes normally.
